// File: rtl/pcie_fifo_burst_pkg.sv
// Shared types and constants for the pcie_fifo burst reader and its helpers.
package pcie_fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_BURST_LEN  = 16;
  localparam int BYTES_PER_BEAT = DEF_DATA_WIDTH / 8;
  localparam int BURST_STRIDE   = DEF_BURST_LEN * BYTES_PER_BEAT;

  // Byte distance between consecutive burst start addresses.
  function automatic int burst_stride_bytes(input int burst_len, input int data_width);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/pcie_skid_buf2.sv
// Two-entry FIFO used as a skid buffer behind a read port with one cycle of latency.
module pcie_skid_buf2 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_occ;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  // A push into a full buffer is dropped; the caller's credit scheme prevents it.
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else if (w_push) begin
      if (r_wr_ptr) r_mem1 <= i_data;
      else          r_mem0 <= i_data;
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_rd_ptr ? r_mem1 : r_mem0;
  assign o_occ   = r_occ;

endmodule

// File: rtl/pcie_fifo_burst_reader.sv
// Drains pcie_fifo in fixed-length framed bursts toward the DMA write engine.
// Optional PCIE_BURST_READER_UNDERRUN_CHK_EN adds a sticky underrun_err output.
module pcie_fifo_burst_reader
  import pcie_fifo_burst_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    LEVEL_WIDTH  = 11,
  parameter int                    BURST_LEN    = 16,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    FRAME_BURSTS = 4800
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic                   burst_done,
  output logic                   frame_done
`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
  ,
  output logic                   underrun_err
`endif
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam int FRM_W = $clog2(FRAME_BURSTS + 1);
  localparam logic [ADDR_WIDTH-1:0]  STRIDE     = ADDR_WIDTH'(burst_stride_bytes(BURST_LEN, DATA_WIDTH));
  localparam logic [CNT_W-1:0]       LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [FRM_W-1:0]       LAST_BURST = FRM_W'(FRAME_BURSTS - 1);
  localparam logic [LEVEL_WIDTH-1:0] BURST_LVL  = LEVEL_WIDTH'(BURST_LEN);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_inflight;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [FRM_W-1:0]        r_burst_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    w_rd_req;
  logic                    w_rd_en;
  logic                    w_valid;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [1:0]              w_occ;
  logic                    w_pop;
  logic                    w_eop_acc;
  logic                    w_frame_last;
  logic [2:0]              w_credit;

  assign w_pop        = w_valid && m_ready;
  assign w_eop_acc    = w_pop && (r_beat_cnt == LAST_BEAT);
  assign w_frame_last = (r_burst_cnt == LAST_BURST);
  // Entries held plus the read still in flight must leave room after this cycle's pop.
  assign w_credit     = {1'b0, w_occ} + {2'b0, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = ARM;
      end
      ARM: begin
        if ((fifo_rd_water_level >= BURST_LVL) && !fifo_rd_empty) w_state_nxt = READ;
      end
      READ: begin
        w_rd_req = (w_credit < (3'd2 + {2'b0, w_pop}));
        w_rd_en  = w_rd_req && !fifo_rd_empty;
        if (w_rd_en && (r_rd_cnt == LAST_BEAT)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_eop_acc) w_state_nxt = enable ? ARM : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_rd_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      if (r_state == ARM)  r_rd_cnt <= '0;
      else if (w_rd_en)    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_addr      <= BASE_ADDR;
    end else if (w_pop) begin
      if (w_eop_acc) begin
        r_beat_cnt <= '0;
        if (w_frame_last) begin
          r_burst_cnt <= '0;
          r_addr      <= BASE_ADDR;
        end else begin
          r_burst_cnt <= r_burst_cnt + FRM_W'(1);
          r_addr      <= r_addr + STRIDE;
        end
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  pcie_skid_buf2 #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (fifo_rd_data),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_data  (w_data),
    .o_occ   (w_occ)
  );

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_valid;
  assign m_data     = w_data;
  assign m_sop      = w_valid && (r_beat_cnt == '0);
  assign m_eop      = w_valid && (r_beat_cnt == LAST_BEAT);
  assign m_addr     = r_addr;
  assign burst_done = w_eop_acc;
  assign frame_done = w_eop_acc && w_frame_last;

`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
  logic r_underrun;
  logic w_ovf;

  assign w_ovf = r_inflight && (w_occ == 2'd2) && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_underrun <= 1'b0;
    else if ((w_rd_req && fifo_rd_empty) || w_ovf) r_underrun <= 1'b1;
  end

  assign underrun_err = r_underrun;
`endif

endmodule

// File: tb/tb_pcie_fifo_burst_reader.sv
// Directed bench for pcie_fifo_burst_reader: phase table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_pcie_fifo_burst_reader;

  localparam int DW = 128;
  localparam int LW = 11;
  localparam int BL = 16;
  localparam int AW = 32;
  localparam int FB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic [LW-1:0] level;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic [AW-1:0] m_addr;
  logic          burst_done;
  logic          frame_done;
`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
  logic          underrun_err;
`endif

  pcie_fifo_burst_reader #(
    .DATA_WIDTH   (DW),
    .LEVEL_WIDTH  (LW),
    .BURST_LEN    (BL),
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (32'h0000_0000),
    .FRAME_BURSTS (FB)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (level),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_data              (m_data),
    .m_sop               (m_sop),
    .m_eop               (m_eop),
    .m_addr              (m_addr),
    .burst_done          (burst_done),
    .frame_done          (frame_done)
`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
    ,
    .underrun_err        (underrun_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: word k holds a pattern derived from k; read data lags rd_en by one cycle.
  int unsigned wptr = 0;
  int unsigned rptr = 0;
  logic        force_empty = 1'b0;

  function automatic logic [DW-1:0] mk_word(input int unsigned idx);
    return {idx ^ 32'hC0DE_0000, ~idx, idx + 32'h1111, idx};
  endfunction

  assign level         = force_empty ? '0 : LW'(wptr - rptr);
  assign fifo_rd_empty = (level == '0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr         <= wptr;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mk_word(rptr);
      rptr         <= rptr + 1;
    end
  end

  // Ready driver: 0 = low, 1 = high, 2 = repeating 1-0-0-1.
  int ready_mode = 1;
  int rcyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
      endcase
    end
  end

  // Stream monitor and reference model, sampled on the falling edge.
  int          ph_rd = 0, ph_beats = 0, ph_bd = 0, ph_fd = 0;
  int          beat_idx = 0, bif = 0;
  int unsigned exp_idx = 0;
  int          issued = 0, accepted = 0;
  bit          chk_nobubble = 1'b1;
  bit          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_sop, prev_eop;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_idx = 0; bif = 0; exp_idx = rptr;
      issued = 0; accepted = 0; prev_hold = 1'b0;
    end else begin
      if (fifo_rd_en) begin ph_rd++; issued++; end
      if (burst_done) ph_bd++;
      if (frame_done) ph_fd++;
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, prev_data);
        chk("hold_sop_eop", {m_sop, m_eop}, {prev_sop, prev_eop});
      end
      if (chk_nobubble && beat_idx != 0) chk("no_bubble", m_valid, 1'b1);
      if (m_valid && m_ready) begin
        accepted++;
        chk("beat_data", m_data, mk_word(exp_idx));
        chk("beat_sop", m_sop, beat_idx == 0);
        chk("beat_eop", m_eop, beat_idx == BL - 1);
        chk("beat_addr", m_addr, 128'(bif * 256));
        chk("burst_done", burst_done, beat_idx == BL - 1);
        chk("frame_done", frame_done, (beat_idx == BL - 1) && (bif == FB - 1));
        exp_idx++;
        ph_beats++;
        if (beat_idx == BL - 1) begin
          beat_idx = 0;
          bif = (bif == FB - 1) ? 0 : bif + 1;
        end else begin
          beat_idx++;
        end
      end else begin
        chk("pulses_idle", {burst_done, frame_done}, 2'b00);
        if (!m_valid) chk("sop_eop_idle", {m_sop, m_eop}, 2'b00);
      end
      chk("outstanding_le2", (issued - accepted) <= 2, 1'b1);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_sop  = m_sop;
      prev_eop  = m_eop;
    end
  end

  typedef struct {
    bit          do_reset;
    int          preload;
    int          rmode;
    int          cycles;
    int          exp_rd;
    int          exp_beats;
    int          exp_bd;
    int          exp_fd;
    logic [31:0] exp_addr;
    int          exp_level;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_counts();
    ph_rd = 0; ph_beats = 0; ph_bd = 0; ph_fd = 0;
  endtask

  task automatic check_phase(input string tag, input int rd, input int beats, input int bd,
                             input int fd, input logic [31:0] addr, input int lvl);
    chk({tag, "_rd_en_count"}, ph_rd, rd);
    chk({tag, "_beat_count"}, ph_beats, beats);
    chk({tag, "_burst_done_count"}, ph_bd, bd);
    chk({tag, "_frame_done_count"}, ph_fd, fd);
    chk({tag, "_m_addr"}, m_addr, addr);
    chk({tag, "_level"}, level, lvl);
  endtask

  initial begin
    //        rst pre rmode cyc  rd beats bd fd addr          level
    vecs[0] = '{1'b0, 15, 1,  40,  0,  0, 0, 0, 32'h0000_0000, 15};
    vecs[1] = '{1'b0,  1, 1,  60, 16, 16, 1, 0, 32'h0000_0100,  0};
    vecs[2] = '{1'b1, 32, 1, 100, 32, 32, 2, 0, 32'h0000_0200,  0};
    vecs[3] = '{1'b0, 16, 2, 150, 16, 16, 1, 1, 32'h0000_0000,  0};
    vecs[4] = '{1'b0, 16, 1,  60, 16, 16, 1, 0, 32'h0000_0100,  0};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst_sop_eop", {m_sop, m_eop}, 2'b00);
    chk("rst_pulses", {burst_done, frame_done}, 2'b00);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_data", m_data, '0);
`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
    chk("rst_underrun_err", underrun_err, 1'b0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_reset) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      enable       = 1'b1;
      ready_mode   = vecs[i].rmode;
      chk_nobubble = (vecs[i].rmode == 1);
      clear_counts();
      wptr += vecs[i].preload;
      repeat (vecs[i].cycles) @(posedge clk);
      #2;
      check_phase($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_beats, vecs[i].exp_bd,
                  vecs[i].exp_fd, vecs[i].exp_addr, vecs[i].exp_level);
    end

    // Enable dropped mid-burst: the burst completes, then no further reads.
    @(posedge clk);
    #1;
    clear_counts();
    wptr += 64;
    for (int k = 0; k < 200 && ph_beats < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("en_drop_reached_beat5", ph_beats >= 5, 1'b1);
    enable = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check_phase("en_drop", 16, 16, 1, 0, 32'h0000_0200, 48);

    // Asynchronous reset in the middle of a burst.
    enable = 1'b1;
    clear_counts();
    for (int k = 0; k < 200 && ph_beats < 8; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_reached_beat8", ph_beats >= 8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", m_valid, 1'b0);
    chk("rst_mid_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst_mid_sop_eop", {m_sop, m_eop}, 2'b00);
    chk("rst_mid_pulses", {burst_done, frame_done}, 2'b00);
    chk("rst_mid_m_addr", m_addr, 32'h0);
    chk("rst_mid_m_data", m_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    wptr += 16;
    repeat (60) @(posedge clk);
    #2;
    check_phase("post_rst", 16, 16, 1, 0, 32'h0000_0100, 0);

`ifdef PCIE_BURST_READER_UNDERRUN_CHK_EN
    chk("underrun_clear", underrun_err, 1'b0);
    @(posedge clk);
    #1;
    chk_nobubble = 1'b0;
    clear_counts();
    wptr += 16;
    for (int k = 0; k < 200 && ph_rd < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("underrun_reached_read", ph_rd >= 3, 1'b1);
    force_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("underrun_err_set", underrun_err, 1'b1);
    force_empty = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    chk("underrun_burst_beats", ph_beats, 16);
    chk("underrun_err_sticky", underrun_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
